// File: rtl/step_clock_ctrl.sv
// Processor clock-enable generator: N_CH debounced buttons, step/run/halt FSM.
// Optional STEP_COUNT counter is built only when STEP_CNT_EN is defined.
module step_clock_ctrl #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 50000,
  parameter int RUN_DIV   = 5000000,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [N_CH-1:0]  BUTTONS,
  input  logic             MODE,
  input  logic             HLT,
  output logic [N_CH-1:0]  DB_LEVEL,
  output logic [N_CH-1:0]  DB_PULSE,
  output logic             CPU_EN,
  output logic             RUNNING,
  output logic             HALTED,
  output logic [CNT_W-1:0] STEP_COUNT
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_HALT
  } state_t;

  logic [N_CH-1:0] sync_p0;
  logic [N_CH-1:0] sync_p1;
  logic [DB_W-1:0] db_cnt [N_CH];

  state_t          state;
  state_t          state_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic            cpu_en_nxt;

  // Stage p0/p1: two-flop synchroniser, then per-channel stability counter
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      DB_LEVEL <= '0;
      DB_PULSE <= '0;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= BUTTONS;
      sync_p1 <= sync_p0;
      for (int i = 0; i < N_CH; i++) begin
        DB_PULSE[i] <= 1'b0;
        if (sync_p1[i] != DB_LEVEL[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            DB_LEVEL[i] <= sync_p1[i];
            DB_PULSE[i] <= sync_p1[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Stage fsm: HLT beats a MODE change, which beats a step pulse or divider tick
  always_comb begin
    state_nxt  = state;
    div_nxt    = '0;
    cpu_en_nxt = 1'b0;
    case (state)
      ST_STOP: begin
        if (HLT) begin
          state_nxt = ST_HALT;
        end else if (MODE) begin
          state_nxt = ST_RUN;
        end else if (DB_PULSE[0]) begin
          cpu_en_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (HLT) begin
          state_nxt = ST_HALT;
        end else if (!MODE) begin
          state_nxt = ST_STOP;
        end else if (div == DIV_LAST) begin
          cpu_en_nxt = 1'b1;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= ST_STOP;
      div     <= '0;
      CPU_EN  <= 1'b0;
      RUNNING <= 1'b0;
      HALTED  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      CPU_EN  <= cpu_en_nxt;
      RUNNING <= (state_nxt == ST_RUN);
      HALTED  <= (state_nxt == ST_HALT);
    end
  end

`ifdef STEP_CNT_EN
  // Stage count: advances together with the CPU_EN strobe it counts
  always_ff @(posedge CLK) begin
    if (Reset) begin
      STEP_COUNT <= '0;
    end else if (cpu_en_nxt) begin
      STEP_COUNT <= STEP_COUNT + CNT_W'(1);
    end
  end
`else
  assign STEP_COUNT = '0;
`endif

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Bench for step_clock_ctrl: directed steps plus random stimulus vs a cycle-level reference model.
module tb_step_clock_ctrl;

  localparam int N_CH      = 2;
  localparam int DB_CYCLES = 4;
  localparam int RUN_DIV   = 3;
  localparam int CNT_W     = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [N_CH-1:0]  BUTTONS;
  logic             MODE;
  logic             HLT;
  logic [N_CH-1:0]  DB_LEVEL;
  logic [N_CH-1:0]  DB_PULSE;
  logic             CPU_EN;
  logic             RUNNING;
  logic             HALTED;
  logic [CNT_W-1:0] STEP_COUNT;

  step_clock_ctrl #(
    .N_CH(N_CH), .DB_CYCLES(DB_CYCLES), .RUN_DIV(RUN_DIV), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .Reset(Reset), .BUTTONS(BUTTONS), .MODE(MODE), .HLT(HLT),
    .DB_LEVEL(DB_LEVEL), .DB_PULSE(DB_PULSE), .CPU_EN(CPU_EN),
    .RUNNING(RUNNING), .HALTED(HALTED), .STEP_COUNT(STEP_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum {M_STOP, M_RUN, M_HALT} mstate_t;
  mstate_t         m_state;
  int              run_cycles;
  int              e_count;
  logic [N_CH-1:0] e_level;
  logic [N_CH-1:0] e_pulse;
  logic            e_en;
  logic [N_CH-1:0] raw_q[$];
  logic [N_CH-1:0] syn_q[$];

  task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a level flips once the synchronised input has shown the
  // opposite value on each of the last DB_CYCLES edges.
  task automatic model_step(input logic rst, input logic [N_CH-1:0] b,
                            input logic mode, input logic hlt);
    logic [N_CH-1:0] synced;
    logic [N_CH-1:0] pulse_prev;
    logic [N_CH-1:0] sample;
    logic            stable;
    if (rst) begin
      m_state    = M_STOP;
      run_cycles = 0;
      e_count    = 0;
      e_level    = '0;
      e_pulse    = '0;
      e_en       = 1'b0;
      raw_q.delete();
      syn_q.delete();
      return;
    end
    pulse_prev = e_pulse;
    raw_q.push_back(b);
    synced = (raw_q.size() >= 3) ? raw_q[raw_q.size() - 3] : '0;
    syn_q.push_back(synced);
    e_pulse = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (syn_q.size() >= DB_CYCLES) begin
        stable = 1'b1;
        for (int k = 1; k <= DB_CYCLES; k++) begin
          sample = syn_q[syn_q.size() - k];
          if (sample[ch] == e_level[ch]) stable = 1'b0;
        end
        if (stable) begin
          e_level[ch] = ~e_level[ch];
          e_pulse[ch] = e_level[ch];
        end
      end
    end
    while (raw_q.size() > 8) void'(raw_q.pop_front());
    while (syn_q.size() > 8) void'(syn_q.pop_front());

    e_en = 1'b0;
    case (m_state)
      M_STOP: begin
        if (hlt) m_state = M_HALT;
        else if (mode) begin
          m_state    = M_RUN;
          run_cycles = 0;
        end else if (pulse_prev[0]) e_en = 1'b1;
      end
      M_RUN: begin
        if (hlt) m_state = M_HALT;
        else if (!mode) m_state = M_STOP;
        else begin
          run_cycles++;
          if (run_cycles % RUN_DIV == 0) e_en = 1'b1;
        end
      end
      default: m_state = M_HALT;
    endcase
`ifdef STEP_CNT_EN
    e_count = (e_count + int'(e_en)) % (1 << CNT_W);
`else
    e_count = 0;
`endif
  endtask

  task automatic tick(input logic rst, input logic [N_CH-1:0] b,
                      input logic mode, input logic hlt);
    Reset   = rst;
    BUTTONS = b;
    MODE    = mode;
    HLT     = hlt;
    @(posedge CLK);
    model_step(rst, b, mode, hlt);
    #1;
    check1("db_level", 16'(DB_LEVEL), 16'(e_level));
    check1("db_pulse", 16'(DB_PULSE), 16'(e_pulse));
    check1("cpu_en",   16'(CPU_EN),   16'(e_en));
    check1("running",  16'(RUNNING),  16'(m_state == M_RUN));
    check1("halted",   16'(HALTED),   16'(m_state == M_HALT));
    if (!e_en) check1("step_count", 16'(STEP_COUNT), 16'(e_count));
  endtask

  function automatic int exp_cnt(input int n);
`ifdef STEP_CNT_EN
    return n % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH-1:0] rb;
    logic            rm;
    logic            rh;
    logic            rr;
    int              guard;

    // Reset and idle
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);

    // Glitch, then a real step press and release
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);
    check1("glitch_level", 16'(DB_LEVEL), 16'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);
    check1("count_after_step", 16'(STEP_COUNT), 16'(exp_cnt(1)));

    // Run mode, then back to stop
    for (int i = 0; i < 20; i++) tick(1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);

    // Halt from run: MODE and presses ignored until reset
    for (int i = 0; i < 5; i++) tick(1'b0, 2'b00, 1'b1, 1'b0);
    tick(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b0, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);
    check1("halted_hold", 16'(HALTED), 16'd1);
    tick(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);

    // Step pulse in the same cycle as HLT
    guard = 0;
    tick(1'b0, 2'b01, 1'b0, 1'b0);
    while (!e_pulse[0] && guard < 20) begin
      tick(1'b0, 2'b01, 1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL pulse_wait: observed no pulse within 20 cycles, required one");
    end
    tick(1'b0, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 2'b00, 1'b0, 1'b0);
    check1("hlt_step_halted", 16'(HALTED), 16'd1);
    tick(1'b1, 2'b00, 1'b0, 1'b0);

    // Seventeen run strobes wrap the 4-bit counter
    for (int i = 0; i < 1 + 17 * RUN_DIV; i++) tick(1'b0, 2'b00, 1'b1, 1'b0);
    tick(1'b0, 2'b00, 1'b0, 1'b0);
    check1("count_wrap", 16'(STEP_COUNT), 16'(exp_cnt(17)));

    // Random traffic
    rb = '0;
    rm = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 5) == 0) rb[ch] = ~rb[ch];
      if ($urandom_range(0, 14) == 0) rm = ~rm;
      rh = ($urandom_range(0, 59) == 0);
      rr = ($urandom_range(0, 79) == 0);
      tick(rr, rb, rm, rh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_clock_ctrl.md
# step_clock_ctrl

Parametrised processor clock-enable generator with multi-channel button debouncing. Replaces the single-button debounce stage in front of the processor: synchronises and debounces `N_CH` push-button inputs and produces a one-cycle `CPU_EN` strobe, issued either per debounced step press or at a fixed divided rate. Honours the processor's `HLT` signal by freezing all strobes until reset. Sits between the board pins and the processing/control units, all on the single board clock.

## Interface
Parameters:
- `N_CH`, 4: number of debounced button channels; channel 0 is the step button (≥1).
- `DB_CYCLES`, 50000: consecutive stable cycles required to accept a new button level (≥1).
- `RUN_DIV`, 5000000: CLK cycles per `CPU_EN` strobe in run mode (≥2).
- `CNT_W`, 16: width of the step counter.

Ports:
- `CLK` in 1: the only clock, rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `BUTTONS` in `N_CH`: raw asynchronous button levels, 1 = pressed.
- `MODE` in 1: 0 = step mode, 1 = run mode; level-sampled.
- `HLT` in 1: halt request from the control unit for the current instruction.
- `DB_LEVEL` out `N_CH`: debounced button levels.
- `DB_PULSE` out `N_CH`: one-cycle pulse on each debounced rising edge.
- `CPU_EN` out 1: one-cycle processor advance strobe.
- `RUNNING` out 1: 1 while in RUN state.
- `HALTED` out 1: 1 while in HALT state.
- `STEP_COUNT` out `CNT_W`: number of `CPU_EN` strobes issued since reset.

## Operation
- Per channel: 2-flop synchroniser, then a counter. The counter increments while the synchronised input differs from `DB_LEVEL[i]` and clears otherwise. When it reaches `DB_CYCLES`, `DB_LEVEL[i]` takes the new value and the counter clears. `DB_PULSE[i]` is 1 only in the cycle `DB_LEVEL[i]` rises 0→1.
- FSM states: STOP, RUN, HALT. Reset state is STOP.
- STOP:
  - `MODE`=1 → RUN.
  - If `DB_PULSE[0]`=1 and `HLT`=0: `CPU_EN`=1 in the next cycle.
  - If `HLT`=1 → HALT.
- RUN:
  - Divider counts 0..`RUN_DIV`-1 and wraps to 0.
  - `CPU_EN`=1 in the cycle after the divider value is `RUN_DIV`-1, provided `HLT`=0 in that cycle.
  - `MODE`=0 → STOP; divider clears.
  - `HLT`=1 → HALT.
- HALT: no `CPU_EN`, and `MODE` and button inputs are ignored by the FSM. Debouncers keep running. Only `Reset` leaves HALT.
- Priority within one cycle: `Reset` > `HLT` > `MODE` change > step pulse / divider tick. A step pulse coinciding with `HLT`=1 is discarded.
- The divider runs only in RUN and is zero in STOP and HALT.
- `STEP_COUNT` increments with each `CPU_EN` strobe and wraps modulo 2^`CNT_W`.

## Timing
- All outputs are registered.
- Reset values: `DB_LEVEL`=0, `DB_PULSE`=0, `CPU_EN`=0, `RUNNING`=0, `HALTED`=0, `STEP_COUNT`=0. Synchroniser and debounce counters and the divider are also cleared.
- Debounce latency: `DB_LEVEL` changes `DB_CYCLES`+2 cycles after a stable input change (2 synchroniser + `DB_CYCLES` count). A glitch shorter than `DB_CYCLES` cycles produces no change.
- Step latency: `CPU_EN` is asserted 1 cycle after `DB_PULSE[0]`.
- Run period: exactly `RUN_DIV` cycles between `CPU_EN` strobes. The first strobe comes `RUN_DIV`+1 cycles after the cycle `MODE`=1 is sampled in STOP.
- `RUNNING` and `HALTED` update in the cycle after the triggering condition is sampled.
- Reset mid-debounce or mid-run returns every output to its reset value at the next edge. A held button must then be re-debounced from 0.

## Configuration
- `STEP_CNT_EN` defined: `STEP_COUNT` counter is implemented as described.
- `STEP_CNT_EN` undefined: no counter logic; `STEP_COUNT` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
Bench parameters: `N_CH`=2, `DB_CYCLES`=4, `RUN_DIV`=3, `CNT_W`=4, `STEP_CNT_EN` defined.
- Reset then idle 20 cycles → all outputs 0, state STOP.
- `BUTTONS[0]` goes high for 3 cycles then low (glitch) → `DB_LEVEL[0]` stays 0, no `CPU_EN`. Hold high for 10 cycles → `DB_LEVEL[0]`=1 at cycle 6, `DB_PULSE[0]` for 1 cycle, `CPU_EN` on the following cycle, `STEP_COUNT`=1.
- `MODE`=1 for 20 cycles → `RUNNING`=1, `CPU_EN` every 3 cycles (first at cycle 4). `MODE`=0 → strobes stop, `RUNNING`=0.
- In RUN, raise `HLT` → `HALTED`=1, no further `CPU_EN` despite `MODE`=1 and step presses. `Reset` → `HALTED`=0, STOP.
- Step press landing in the same cycle as `HLT`=1 → no `CPU_EN`, state HALT.
- 17 strobes in run mode → `STEP_COUNT` wraps to 1. Recompile without `STEP_CNT_EN` → `STEP_COUNT` stays 0, all other results unchanged.
